// File: rtl/rx_rst_sequencer_pkg.sv
// Shared encodings for the RX reset sequencer.
// Holds the FSM state enum and the counter-clear register address.
package rx_rst_sequencer_pkg;

    typedef enum logic [1:0] {
        S_SEQ_IDLE    = 2'd0,
        S_SEQ_ASSERT  = 2'd1,
        S_SEQ_HOLDOFF = 2'd2
    } seq_state_t;

    localparam logic [4:0] CLR_ADDR = 5'd31;

endpackage

// File: rtl/rx_rst_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear that beats increment.
// Ports: clk, rst (async high), clr, inc, count[WIDTH-1:0].
module rx_rst_sequencer_sat_counter #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_rst_sequencer.sv
// RX reset sequencer: turns watchdog request edges into a timed
// registered reset pulse for the RX pipeline plus a hold-off window.
// Ports: clk, rst (async high), enable, rst_req, rst_cause[4:0],
//   rst_len, holdoff_len, slv_reg_wren_signal, axi_awaddr_core[4:0]
//   -> rx_pipe_rst, rst_ack, seq_state[1:0], accepted_counter,
//      dropped_counter, last_cause[4:0].
// Optional: RX_RST_SEQ_CAUSE_LATCH_EN enables the last_cause register;
// without it last_cause reads 0 and rst_cause is unused.
module rx_rst_sequencer
    import rx_rst_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 22,
    parameter int RST_LEN_WIDTH = 8,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     rst_req,
    input  logic [4:0]               rst_cause,
    input  logic [RST_LEN_WIDTH-1:0] rst_len,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
    input  logic                     slv_reg_wren_signal,
    input  logic [4:0]               axi_awaddr_core,
    output logic                     rx_pipe_rst,
    output logic                     rst_ack,
    output logic [1:0]               seq_state,
    output logic [COUNTER_WIDTH-1:0] accepted_counter,
    output logic [COUNTER_WIDTH-1:0] dropped_counter,
    output logic [4:0]               last_cause
);

    // One down-counter serves both phases, so size it for the wider one.
    localparam int CNT_W = (RST_LEN_WIDTH > HOLDOFF_WIDTH) ?
                           RST_LEN_WIDTH : HOLDOFF_WIDTH;

    seq_state_t               state;
    seq_state_t               state_n;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_n;
    logic [CNT_W-1:0]         pulse_len;
    logic [HOLDOFF_WIDTH-1:0] hold_q;
    logic                     rst_req_d;
    logic                     req_edge;
    logic                     accept;
    logic                     drop;
    logic                     clr;

    assign req_edge  = rst_req & ~rst_req_d;
    assign clr       = slv_reg_wren_signal &&
                       (axi_awaddr_core == CLR_ADDR);
    assign accept    = req_edge && enable && (state == S_SEQ_IDLE);
    assign drop      = req_edge && (state != S_SEQ_IDLE);
    assign pulse_len = (rst_len == '0) ? CNT_W'(1) : CNT_W'(rst_len);
    assign seq_state = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_SEQ_IDLE: begin
                if (accept) begin
                    state_n = S_SEQ_ASSERT;
                    cnt_n   = pulse_len;
                end
            end
            S_SEQ_ASSERT: begin
                if (cnt == CNT_W'(1)) begin
                    if (hold_q == '0) begin
                        state_n = S_SEQ_IDLE;
                    end else begin
                        state_n = S_SEQ_HOLDOFF;
                        cnt_n   = CNT_W'(hold_q);
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_SEQ_HOLDOFF: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = S_SEQ_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = S_SEQ_IDLE;
            end
        endcase
    end

    // Edge register resets high so a request already asserted at
    // reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_SEQ_IDLE;
            cnt         <= '0;
            hold_q      <= '0;
            rst_req_d   <= 1'b1;
            rx_pipe_rst <= 1'b0;
            rst_ack     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rst_req_d   <= rst_req;
            rx_pipe_rst <= (state_n == S_SEQ_ASSERT);
            rst_ack     <= accept;
            // Hold-off length is captured with the request so that
            // later changes cannot stretch a sequence in flight.
            if (accept) begin
                hold_q <= holdoff_len;
            end
        end
    end

    rx_rst_sequencer_sat_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_acc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (accept),
        .count (accepted_counter)
    );

    rx_rst_sequencer_sat_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (drop),
        .count (dropped_counter)
    );

`ifdef RX_RST_SEQ_CAUSE_LATCH_EN
    logic [4:0] cause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q <= '0;
        end else if (clr) begin
            cause_q <= '0;
        end else if (accept) begin
            cause_q <= rst_cause;
        end
    end

    assign last_cause = cause_q;
`else
    logic unused_cause;

    assign unused_cause = ^rst_cause;
    assign last_cause   = '0;
`endif

endmodule

// File: tb/tb_rx_rst_sequencer.sv
// Self-checking bench for rx_rst_sequencer: directed steps then
// random traffic checked against a window-based reference model.
module tb_rx_rst_sequencer;

    localparam int CW = 4;
    localparam int RW = 8;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          rst_req;
    logic [4:0]    cause;
    logic [RW-1:0] rlen;
    logic [HW-1:0] hlen;
    logic          wr;
    logic [4:0]    addr;
    logic          rx_pipe_rst;
    logic          rst_ack;
    logic [1:0]    seq_state;
    logic [CW-1:0] acc_c;
    logic [CW-1:0] drp_c;
    logic [4:0]    last_cause;

    always #5 clk = ~clk;

    rx_rst_sequencer #(
        .COUNTER_WIDTH (CW),
        .RST_LEN_WIDTH (RW),
        .HOLDOFF_WIDTH (HW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .rst_req             (rst_req),
        .rst_cause           (cause),
        .rst_len             (rlen),
        .holdoff_len         (hlen),
        .slv_reg_wren_signal (wr),
        .axi_awaddr_core     (addr),
        .rx_pipe_rst         (rx_pipe_rst),
        .rst_ack             (rst_ack),
        .seq_state           (seq_state),
        .accepted_counter    (acc_c),
        .dropped_counter     (drp_c),
        .last_cause          (last_cause)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one accepted sequence is a time window
    // [a_at+1 .. a_at+a_len] pulsing, then a_hold hold-off cycles.
    int         m_acc;
    int         m_drp;
    logic [4:0] m_cause;
    bit         m_prev;
    int         a_at;
    int         a_len;
    int         a_hold;

    function automatic int exp_state(int c);
        if (c > a_at && c <= a_at + a_len) return 1;
        if (c > a_at + a_len && c <= a_at + a_len + a_hold) return 2;
        return 0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_drp   = 0;
        m_cause = '0;
        m_prev  = 1'b1;
        a_at    = -100000;
        a_len   = 0;
        a_hold  = 0;
    endtask

    task automatic check_outputs();
        int st;
        st = exp_state(cyc);
        check("rx_pipe_rst", 32'(rx_pipe_rst), 32'(st == 1));
        check("rst_ack", 32'(rst_ack), 32'(cyc == a_at + 1));
        check("seq_state", 32'(seq_state), 32'(st));
        check("accepted", 32'(acc_c), 32'(m_acc));
        check("dropped", 32'(drp_c), 32'(m_drp));
        check("last_cause", 32'(last_cause), 32'(m_cause));
    endtask

    // Check current outputs, drive one cycle of inputs, advance model.
    task automatic step(int req, int en, int w, int ad, int cs,
                        int rl, int hl);
        int st;
        int sat;
        bit e;
        bit acc;
        sat = (1 << CW) - 1;
        check_outputs();
        st      = exp_state(cyc);
        rst_req = (req != 0);
        enable  = (en != 0);
        wr      = (w != 0);
        addr    = 5'(ad);
        cause   = 5'(cs);
        rlen    = RW'(rl);
        hlen    = HW'(hl);
        e       = (req != 0) && !m_prev;
        m_prev  = (req != 0);
        acc     = e && (en != 0) && (st == 0);
        if (acc) begin
            a_at   = cyc;
            a_len  = (rl == 0) ? 1 : rl;
            a_hold = hl;
        end
        if (w != 0 && ad == 31) begin
            m_acc   = 0;
            m_drp   = 0;
            m_cause = '0;
        end else begin
            if (acc) begin
                m_acc = (m_acc < sat) ? m_acc + 1 : sat;
`ifdef RX_RST_SEQ_CAUSE_LATCH_EN
                m_cause = 5'(cs);
`endif
            end
            if (e && st != 0) begin
                m_drp = (m_drp < sat) ? m_drp + 1 : sat;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int r;
        int en;
        int w;
        int ad;
        rst     = 1'b1;
        enable  = 1'b0;
        rst_req = 1'b0;
        cause   = '0;
        rlen    = '0;
        hlen    = '0;
        wr      = 1'b0;
        addr    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request: 4-cycle pulse, 10-cycle hold-off.
        repeat (20) step(0, 1, 0, 0, 0, 4, 10);
        step(1, 1, 0, 0, 5'h15, 4, 10);
        repeat (20) step(1, 1, 0, 0, 0, 4, 10);

        // Zero lengths: one-cycle pulse, quick re-accept.
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 3, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 9, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0, 0);

        // Drops during busy window; lengths changed mid-sequence.
        step(0, 1, 1, 31, 0, 8, 100);
        step(1, 1, 0, 0, 4, 8, 100);
        repeat (3) begin
            step(0, 1, 0, 0, 0, 2, 3);
            step(1, 0, 0, 0, 0, 2, 3);
        end
        repeat (110) step(0, 1, 0, 0, 0, 2, 3);
        step(1, 1, 0, 0, 6, 8, 100);
        repeat (112) step(0, 1, 0, 0, 0, 8, 100);

        // Disabled request ignored; enable drop keeps full pulse.
        step(0, 0, 1, 31, 0, 8, 0);
        step(1, 0, 0, 0, 2, 8, 0);
        repeat (3) step(0, 0, 0, 0, 0, 8, 0);
        step(0, 1, 0, 0, 0, 8, 0);
        step(1, 1, 0, 0, 11, 8, 0);
        repeat (3) step(1, 0, 0, 0, 0, 8, 0);
        repeat (8) step(0, 0, 0, 0, 0, 8, 0);

        // Clear beats a same-cycle accept; wrong address ignored.
        step(0, 1, 1, 30, 0, 3, 2);
        step(1, 1, 1, 31, 7, 3, 2);
        repeat (8) step(0, 1, 0, 0, 0, 3, 2);

        // Saturation of the accepted counter.
        repeat (20) begin
            step(1, 1, 0, 0, $urandom_range(0, 31), 0, 0);
            step(0, 1, 0, 0, 0, 0, 0);
        end

        // Async reset in third assert cycle; held request ignored.
        step(0, 1, 0, 0, 0, 6, 4);
        step(1, 1, 0, 0, 13, 6, 4);
        step(1, 1, 0, 0, 0, 6, 4);
        step(1, 1, 0, 0, 0, 6, 4);
        check("pre_rst_pulse", 32'(rx_pipe_rst), 32'(1));
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1, 1, 0, 0, 0, 6, 4);
        step(0, 1, 0, 0, 0, 6, 4);
        step(1, 1, 0, 0, 17, 6, 4);
        repeat (12) step(0, 1, 0, 0, 0, 6, 4);

        // Random traffic.
        repeat (3000) begin
            r  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            en = ($urandom_range(0, 7) != 0) ? 1 : 0;
            w  = ($urandom_range(0, 40) == 0) ? 1 : 0;
            ad = ($urandom_range(0, 1) != 0) ? 31 : $urandom_range(0, 31);
            step(r, en, w, ad, $urandom_range(0, 31),
                 $urandom_range(0, 5), $urandom_range(0, 8));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
